// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, ALU-class bounds and sequencer states.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package cpu_pkg;

    // Opcode encodings used by the issuer and the ALU sequencer
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_MUL = 5'b01111;
    localparam logic [4:0] OP_DIV = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10010;
    localparam logic [4:0] OP_BR  = 5'b10011;

    // ALU-class opcodes occupy the contiguous range add..not
    localparam logic [4:0] ALU_FIRST = OP_ADD;
    localparam logic [4:0] ALU_LAST  = OP_NOT;

    // Width of the multi-cycle wait counter
    localparam int MD_CNT_W = 6;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LD_A    = 3'd1,
        S_LD_B    = 3'd2,
        S_EXEC    = 3'd3,
        S_MD_WAIT = 3'd4,
        S_WB      = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // True when the opcode falls inside the ALU-class range
    function automatic logic is_alu_range(input logic [4:0] op);
        return (op >= ALU_FIRST) && (op <= ALU_LAST);
    endfunction

endpackage

// File: rtl/alu_md_counter.sv
// Down-counter timing the multiply/divide wait; load, decrement, zero flag.
// Latency: load and decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module alu_md_counter
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                clear,
    input  logic                load,
    input  logic [MD_CNT_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [MD_CNT_W-1:0] count;

    // Count register: load has priority over decrement, never wraps below zero
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// ALU operation sequencer: accepts an opcode and steps operand loads, execute, optional mul/div wait, writeback.
// Latency: 5 cycles accept-to-done for single-cycle ops, 5+N for mul/div (N = MUL_CYCLES/DIV_CYCLES), 1 for illegal ops.
// Backpressure: op_ready is high only in IDLE; op_valid while busy is ignored. Build macro ALU_SEQ_DIV_EN enables div.
module alu_seq_ctrl
    import cpu_pkg::*;
#(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       op_valid,
    input  logic [4:0] opcode,
    output logic       op_ready,
    output logic [4:0] alu_op,
    output logic       a_load,
    output logic       b_load,
    output logic       z_load,
    output logic       hi_load,
    output logic       lo_load,
    output logic       busy,
    output logic       done,
    output logic       illegal
);

    // Reject out-of-range wait counts at elaboration
    if (MUL_CYCLES < 1 || MUL_CYCLES > 63) begin : g_bad_mul_cycles
        $error("MUL_CYCLES must be in 1..63");
    end
    if (DIV_CYCLES < 1 || DIV_CYCLES > 63) begin : g_bad_div_cycles
        $error("DIV_CYCLES must be in 1..63");
    end

    // Counter is loaded with N-1 so that MD_WAIT exits on the zero flag after exactly N cycles
    localparam logic [MD_CNT_W-1:0] MUL_LOAD = MD_CNT_W'(MUL_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic                accept;
    logic                cnt_load;
    logic                cnt_dec;
    logic                cnt_zero;
    logic [MD_CNT_W-1:0] cnt_load_val;

    // Opcodes this build can execute; div drops out when the divider is not built
    function automatic logic op_supported(input logic [4:0] op);
`ifdef ALU_SEQ_DIV_EN
        return is_alu_range(op);
`else
        return is_alu_range(op) && (op != OP_DIV);
`endif
    endfunction

    // Opcodes that need the multi-cycle wait and hi/lo writeback
    function automatic logic op_multicycle(input logic [4:0] op);
`ifdef ALU_SEQ_DIV_EN
        return (op == OP_MUL) || (op == OP_DIV);
`else
        return (op == OP_MUL);
`endif
    endfunction

`ifdef ALU_SEQ_DIV_EN
    localparam logic [MD_CNT_W-1:0] DIV_LOAD = MD_CNT_W'(DIV_CYCLES - 1);
    assign cnt_load_val = (alu_op == OP_DIV) ? DIV_LOAD : MUL_LOAD;
`else
    assign cnt_load_val = MUL_LOAD;
`endif

    assign accept = op_valid && (state == S_IDLE);

    // State register
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Opcode register: captured on acceptance and held for the whole operation
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            alu_op <= '0;
        end else if (accept) begin
            alu_op <= opcode;
        end
    end

    // Next-state and output decode; outputs depend only on state and the registered opcode
    always_comb begin
        state_nxt = state;
        op_ready  = 1'b0;
        a_load    = 1'b0;
        b_load    = 1'b0;
        z_load    = 1'b0;
        hi_load   = 1'b0;
        lo_load   = 1'b0;
        done      = 1'b0;
        illegal   = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    state_nxt = op_supported(opcode) ? S_LD_A : S_DONE;
                end
            end
            S_LD_A: begin
                a_load    = 1'b1;
                state_nxt = S_LD_B;
            end
            S_LD_B: begin
                b_load    = 1'b1;
                cnt_load  = 1'b1;
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = op_multicycle(alu_op) ? S_MD_WAIT : S_WB;
            end
            S_MD_WAIT: begin
                if (cnt_zero) begin
                    state_nxt = S_WB;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            S_WB: begin
                if (op_multicycle(alu_op)) begin
                    hi_load = 1'b1;
                    lo_load = 1'b1;
                end else begin
                    z_load = 1'b1;
                end
                state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                illegal   = !op_supported(alu_op);
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    alu_md_counter u_md_counter (
        .clk      (clk),
        .clear    (clear),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: cycle-by-cycle output checks for add, mul, div, br, clear and busy-ignore.
// Latency: n/a.
// Backpressure: n/a. Honours ALU_SEQ_DIV_EN for the div expectations.
module tb_alu_seq_ctrl;

    logic       clk;
    logic       clear;
    logic       op_valid;
    logic [4:0] opcode;
    logic       op_ready;
    logic [4:0] alu_op;
    logic       a_load;
    logic       b_load;
    logic       z_load;
    logic       hi_load;
    logic       lo_load;
    logic       busy;
    logic       done;
    logic       illegal;

    int n_tests;
    int n_fail;

    // Output vector order: a_load b_load z_load hi_load lo_load busy done illegal op_ready
    logic [8:0] obs;
    assign obs = {a_load, b_load, z_load, hi_load, lo_load, busy, done, illegal, op_ready};

    localparam logic [8:0] P_IDLE = 9'b00000_0001;
    localparam logic [8:0] P_LDA  = 9'b10000_1000;
    localparam logic [8:0] P_LDB  = 9'b01000_1000;
    localparam logic [8:0] P_EX   = 9'b00000_1000;
    localparam logic [8:0] P_WBZ  = 9'b00100_1000;
    localparam logic [8:0] P_WBM  = 9'b00011_1000;
    localparam logic [8:0] P_DN   = 9'b00000_1100;
    localparam logic [8:0] P_DNI  = 9'b00000_1110;

    localparam logic [4:0] C_ADD = 5'b00011;
    localparam logic [4:0] C_SUB = 5'b00100;
    localparam logic [4:0] C_MUL = 5'b01111;
    localparam logic [4:0] C_DIV = 5'b10000;
    localparam logic [4:0] C_NOT = 5'b10010;
    localparam logic [4:0] C_BR  = 5'b10011;

    alu_seq_ctrl #(
        .MUL_CYCLES (4),
        .DIV_CYCLES (32)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .op_valid (op_valid),
        .opcode   (opcode),
        .op_ready (op_ready),
        .alu_op   (alu_op),
        .a_load   (a_load),
        .b_load   (b_load),
        .z_load   (z_load),
        .hi_load  (hi_load),
        .lo_load  (lo_load),
        .busy     (busy),
        .done     (done),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_out(input string tag, input logic [8:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s outputs observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_op(input string tag, input logic [4:0] exp);
        n_tests++;
        assert (alu_op === exp) else begin
            n_fail++;
            $error("FAIL %s alu_op observed=%b expected=%b", tag, alu_op, exp);
        end
    endtask

    // Advance one cycle, sample 1ns after the edge, check outputs and alu_op
    task automatic cyc(input string tag, input logic [8:0] exp, input logic [4:0] exp_op);
        @(posedge clk);
        #1;
        chk_out(tag, exp);
        chk_op(tag, exp_op);
    endtask

    // Offer an opcode in the current (IDLE) cycle; it is accepted at the next edge
    task automatic offer(input logic [4:0] op);
        op_valid = 1'b1;
        opcode   = op;
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        clear    = 1'b1;
        op_valid = 1'b0;
        opcode   = 5'b00000;

        // Reset state while clear is held
        #1;
        chk_out("reset_outputs", P_IDLE);
        chk_op("reset_alu_op", 5'b00000);
        @(posedge clk);
        @(posedge clk);
        #1;
        clear = 1'b0;
        cyc("post_reset", P_IDLE, 5'b00000);

        // add: a_load@1 b_load@2 exec@3 z_load@4 done@5 ready@6
        offer(C_ADD);
        cyc("add_c1_lda", P_LDA, C_ADD);
        op_valid = 1'b0;
        cyc("add_c2_ldb", P_LDB, C_ADD);
        cyc("add_c3_exec", P_EX, C_ADD);
        cyc("add_c4_wb", P_WBZ, C_ADD);
        cyc("add_c5_done", P_DN, C_ADD);
        cyc("add_c6_idle", P_IDLE, C_ADD);

        // mul: MD_WAIT 4..7, hi/lo@8, done@9
        offer(C_MUL);
        cyc("mul_c1_lda", P_LDA, C_MUL);
        op_valid = 1'b0;
        cyc("mul_c2_ldb", P_LDB, C_MUL);
        cyc("mul_c3_exec", P_EX, C_MUL);
        for (int i = 4; i <= 7; i++) begin
            cyc($sformatf("mul_c%0d_wait", i), P_EX, C_MUL);
        end
        cyc("mul_c8_wb", P_WBM, C_MUL);
        cyc("mul_c9_done", P_DN, C_MUL);
        cyc("mul_c10_idle", P_IDLE, C_MUL);

        // div: full 32-cycle wait when built in, otherwise illegal
        offer(C_DIV);
`ifdef ALU_SEQ_DIV_EN
        cyc("div_c1_lda", P_LDA, C_DIV);
        op_valid = 1'b0;
        cyc("div_c2_ldb", P_LDB, C_DIV);
        cyc("div_c3_exec", P_EX, C_DIV);
        for (int i = 4; i <= 35; i++) begin
            cyc($sformatf("div_c%0d_wait", i), P_EX, C_DIV);
        end
        cyc("div_c36_wb", P_WBM, C_DIV);
        cyc("div_c37_done", P_DN, C_DIV);
        cyc("div_c38_idle", P_IDLE, C_DIV);
`else
        cyc("div_c1_illegal", P_DNI, C_DIV);
        op_valid = 1'b0;
        cyc("div_c2_idle", P_IDLE, C_DIV);
`endif

        // br: non-ALU opcode goes straight to DONE with illegal
        offer(C_BR);
        cyc("br_c1_illegal", P_DNI, C_BR);
        op_valid = 1'b0;
        cyc("br_c2_idle", P_IDLE, C_BR);

        // clear during mul MD_WAIT at cycle 5
        offer(C_MUL);
        cyc("clr_mul_c1_lda", P_LDA, C_MUL);
        op_valid = 1'b0;
        cyc("clr_mul_c2_ldb", P_LDB, C_MUL);
        cyc("clr_mul_c3_exec", P_EX, C_MUL);
        cyc("clr_mul_c4_wait", P_EX, C_MUL);
        cyc("clr_mul_c5_wait", P_EX, C_MUL);
        clear = 1'b1;
        #1;
        chk_out("clr_immediate", P_IDLE);
        chk_op("clr_immediate", 5'b00000);
        cyc("clr_held_1", P_IDLE, 5'b00000);
        cyc("clr_held_2", P_IDLE, 5'b00000);
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc($sformatf("clr_after_%0d", i), P_IDLE, 5'b00000);
        end

        // sub after clear completes normally with done at cycle 5
        offer(C_SUB);
        cyc("sub_c1_lda", P_LDA, C_SUB);
        op_valid = 1'b0;
        cyc("sub_c2_ldb", P_LDB, C_SUB);
        cyc("sub_c3_exec", P_EX, C_SUB);
        cyc("sub_c4_wb", P_WBZ, C_SUB);
        cyc("sub_c5_done", P_DN, C_SUB);
        cyc("sub_c6_idle", P_IDLE, C_SUB);

        // not with op_valid held high and a different opcode while busy
        offer(C_NOT);
        cyc("not_c1_lda", P_LDA, C_NOT);
        opcode = C_ADD;
        cyc("not_c2_ldb", P_LDB, C_NOT);
        cyc("not_c3_exec", P_EX, C_NOT);
        cyc("not_c4_wb", P_WBZ, C_NOT);
        cyc("not_c5_done", P_DN, C_NOT);
        // Cycle after DONE: IDLE, held op_valid now accepted
        cyc("not_c6_idle", P_IDLE, C_NOT);
        cyc("b2b_add_c1_lda", P_LDA, C_ADD);
        op_valid = 1'b0;
        cyc("b2b_add_c2_ldb", P_LDB, C_ADD);
        cyc("b2b_add_c3_exec", P_EX, C_ADD);
        cyc("b2b_add_c4_wb", P_WBZ, C_ADD);
        cyc("b2b_add_c5_done", P_DN, C_ADD);
        cyc("b2b_add_c6_idle", P_IDLE, C_ADD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
